// File: rtl/sys_reset_req_if.sv
// Request/status and reset-handshake signals between control logic, the reset
// initiator and the per-domain reset generators.
// slave = initiator view, master = control/domain-model view.
interface sys_reset_req_if #(
    parameter int SYS_CLK_NUM = 1
) ();
    logic                   req;
    logic                   sys_rst_n;
    logic [SYS_CLK_NUM-1:0] perif_rst_n_in;
    logic                   busy;
    logic                   done;
    logic                   err_timeout;

    modport slave (
        input  req,
        input  perif_rst_n_in,
        output sys_rst_n,
        output busy,
        output done,
        output err_timeout
    );

    modport master (
        output req,
        output perif_rst_n_in,
        input  sys_rst_n,
        input  busy,
        input  done,
        input  err_timeout
    );
endinterface

// File: rtl/sys_reset_req.sv
// Software-triggered reset initiator: holds sys_rst_n low, then confirms every domain reset applied and released.
// Latency: sys_rst_n falls one cycle after req; low >= HOLD_CYCLES; each phase bounded by TIMEOUT_CYCLES.
// Backpressure: req is sampled only in IDLE; requests while busy are dropped, not queued.
module sys_reset_req #(
    parameter int SYS_CLK_NUM    = 1,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sys_reset_req_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   err_q, err_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    (* async_reg = "true" *) logic [SYS_CLK_NUM-1:0] sync1_q;
    (* async_reg = "true" *) logic [SYS_CLK_NUM-1:0] sync2_q;

    logic all_low;
    logic all_high;

    // Two-flop synchronizer for the domain resets; resets to "deasserted".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.perif_rst_n_in;
            sync2_q <= sync1_q;
        end
    end

    assign all_low  = &(~sync2_q);
    assign all_high = &sync2_q;

    // Phase counter saturates instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic; outputs are derived from the next state so they leave flops directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_ASSERT: begin
                cnt_d = cnt_inc;
                // Exit is checked first so a coincident timeout is not flagged.
                if ((cnt_q >= HOLD_LAST) && all_low) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_inc;
                if (all_high) begin
                    state_d = S_DONE;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sys_rst_n_d = (state_d != S_ASSERT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, counter and registered outputs; reset returns everything to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            sys_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            sys_rst_n_q <= sys_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_sys_reset_req.sv
// Bench for sys_reset_req: directed sequences with a domain-reset model.
// Expected per-sequence results are queued at stimulus time and checked on each done pulse.
// Measured: sys_rst_n low cycles, cycles from release to done, err_timeout, low periods.
module tb_sys_reset_req;
    localparam int N     = 2;
    localparam int HOLD  = 16;
    localparam int TO    = 64;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int low;
        int rel;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    sys_reset_req_if #(.SYS_CLK_NUM(N)) bus ();

    sys_reset_req #(
        .SYS_CLK_NUM   (N),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Domain model: each domain drops lo_dly[i] cycles after sys_rst_n falls,
    // all rise hi_dly cycles after sys_rst_n rises.
    int   lo_dly[N];
    int   hi_dly = 5;
    int   since_fall = 100000;
    int   since_rise = 100000;
    logic prev_m = 1'b1;

    always @(posedge clk) begin
        #1;
        if (prev_m && !bus.sys_rst_n) since_fall = 0;
        else if (since_fall < 100000) since_fall++;
        if (!prev_m && bus.sys_rst_n) since_rise = 0;
        else if (since_rise < 100000) since_rise++;
        prev_m = bus.sys_rst_n;
        for (int i = 0; i < N; i++)
            if (!bus.sys_rst_n && since_fall >= lo_dly[i]) bus.perif_rst_n_in[i] = 1'b0;
        if (bus.sys_rst_n && since_rise >= hi_dly) bus.perif_rst_n_in = '1;
    end

    // Monitor: measures each sequence and checks it against the queued expectation on done.
    int   low_cnt = 0;
    int   falls = 0;
    int   rise_cyc = 0;
    logic prev_n = 1'b1;
    logic prev_done = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            low_cnt   = 0;
            falls     = 0;
            prev_n    = 1'b1;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_one_cycle", int'(bus.done), 0);
            prev_done = bus.done;
            if (!bus.sys_rst_n) low_cnt++;
            if (prev_n && !bus.sys_rst_n) falls++;
            if (!prev_n && bus.sys_rst_n) rise_cyc = cyc;
            prev_n = bus.sys_rst_n;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("low_cycles", low_cnt, e.low);
                    chk("release_to_done", cyc - rise_cyc, e.rel);
                    chk("err_timeout", int'(bus.err_timeout), e.err);
                    chk("low_periods", falls, 1);
                end
                low_cnt = 0;
                falls   = 0;
            end
        end
    end

    task automatic set_model(input int l0, input int l1, input int h);
        lo_dly[0] = l0;
        lo_dly[1] = l1;
        hi_dly    = h;
    endtask

    task automatic push(input int low, input int rel, input int err);
        exp_t x;
        x.low = low;
        x.rel = rel;
        x.err = err;
        sb.push_back(x);
    endtask

    task automatic pulse_req();
        @(posedge clk);
        #1 bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb.size() == 0 && bus.busy == 1'b0) && n < budget);
        if (n >= budget) begin
            chk({"timeout_", tag}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sys_rst_n != 1'b0 && n < budget);
        if (n >= budget) chk("timeout_fall", int'(bus.sys_rst_n), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bus.req = 1'b0;
        set_model(3, 3, 5);
        repeat (3) @(negedge clk);
        chk("rst_sys_rst_n", int'(bus.sys_rst_n), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err_timeout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Nominal: low HOLD cycles; done 5 model + 2 sync + 1 FSM cycles after release.
        set_model(3, 3, 5);
        push(HOLD, 8, 0);
        pulse_req();
        wait_idle("nominal", 300);

        // Slow domain 1 drops 40 cycles after fall: visible 2 sync cycles later,
        // FSM leaves ASSERT on the next edge, so low = 40 + 2 + 1.
        set_model(3, 40, 5);
        push(43, 8, 0);
        pulse_req();
        wait_idle("slow", 300);

        // Assert timeout: domains never drop; release and done on the same edge.
        set_model(NEVER, NEVER, 5);
        push(TO, 0, 1);
        pulse_req();
        wait_idle("assert_to", 300);
        chk("err_sticky_idle", int'(bus.err_timeout), 1);

        // Next accepted request clears the sticky error.
        set_model(3, 3, 5);
        push(HOLD, 8, 0);
        pulse_req();
        @(negedge clk);
        chk("accept_busy", int'(bus.busy), 1);
        chk("accept_err_clear", int'(bus.err_timeout), 0);
        wait_idle("err_clear", 300);

        // Release timeout: domains stay low; RELEASE lasts TO cycles.
        set_model(3, 3, NEVER);
        push(HOLD, TO, 1);
        pulse_req();
        wait_idle("release_to", 300);
        set_model(3, 3, 5);
        repeat (4) @(posedge clk);

        // req while busy is ignored.
        push(HOLD, 8, 0);
        pulse_req();
        wait_fall(20);
        for (int k = 0; k < 2; k++) begin
            repeat (4) @(posedge clk);
            #1 bus.req = 1'b1;
            @(posedge clk);
            #1 bus.req = 1'b0;
        end
        wait_idle("busy_req", 300);

        // req held through DONE starts a second full sequence.
        push(HOLD, 8, 0);
        push(HOLD, 8, 0);
        @(posedge clk);
        #1 bus.req = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.done != 1'b1 && n < 300);
            if (n >= 300) chk("timeout_held_done", int'(bus.done), 1);
        end
        repeat (2) @(posedge clk);
        #1 bus.req = 1'b0;
        wait_idle("held_req", 300);

        // Asynchronous reset in the 8th ASSERT cycle aborts with no done pulse.
        push(HOLD, 8, 0);
        void'(sb.pop_back());
        pulse_req();
        wait_fall(20);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sys_rst_n", int'(bus.sys_rst_n), 1);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_done", int'(bus.done), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_idle", int'(bus.busy), 0);

        push(HOLD, 8, 0);
        pulse_req();
        wait_idle("post_rst", 300);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
